linked_list_pop_scheduler: RTL

Downstream consumer of the shared `linked_list_fifo`. It watches the per-queue `empty` flags, picks a non-empty enabled queue round-robin, and issues `pop`/`pop_sel` to the shared FIFO. It captures the popped word into a 2-entry output buffer and presents it on a valid/ready stream tagged with its source queue. No path exists from `out_ready` to `fifo_pop`.

---
 rtl/linked_list_pop_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/linked_list_pop_scheduler.sv
// Round-robin pop scheduler for the shared linked-list FIFO: picks an eligible queue,
// pops it, and holds popped words in a 2-entry buffer feeding a valid/ready stream.
module linked_list_pop_scheduler #(
    parameter int WIDTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data_out,
    output logic                 fifo_pop,
    output logic [SEL_WIDTH-1:0] fifo_pop_sel,
    input  logic [NUM_FIFOS-1:0] q_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_sel
);

    logic [NUM_FIFOS-1:0] elig;
    logic [SEL_WIDTH-1:0] grant;
    int                   grant_dist;
    int                   best_dist;

    logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]     data_q [2];
    logic [WIDTH-1:0]     data_d [2];
    logic [SEL_WIDTH-1:0] sel_q  [2];
    logic [SEL_WIDTH-1:0] sel_d  [2];
    logic                 deq;

    assign elig = ~fifo_empty & q_en;

    // The winner is the eligible queue at the smallest circular distance past last_grant.
    always_comb begin
        grant      = last_grant_q;
        best_dist  = NUM_FIFOS;
        grant_dist = 0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (elig[i]) begin
                grant_dist = (i + NUM_FIFOS - 1 - int'(last_grant_q)) % NUM_FIFOS;
                if (grant_dist < best_dist) begin
                    best_dist = grant_dist;
                    grant     = SEL_WIDTH'(i);
                end
            end
        end
    end

    assign fifo_pop     = rst_n & (|elig) & (cnt_q != 2'd2);
    assign fifo_pop_sel = fifo_pop ? grant : last_grant_q;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_sel   = sel_q[rd_ptr_q];
    assign deq       = out_valid & out_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_d       = data_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q + 2'(fifo_pop) - 2'(deq);
        if (fifo_pop) begin
            data_d[wr_ptr_q] = fifo_data_out;
            sel_d[wr_ptr_q]  = fifo_pop_sel;
            wr_ptr_d         = ~wr_ptr_q;
            last_grant_d     = fifo_pop_sel;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= SEL_WIDTH'(NUM_FIFOS - 1);
            cnt_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                sel_q[i]  <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
        end
    end

endmodule
